sd_spi_byte_engine: RTL and testbench
=====================================

# sd_spi_byte_engine

Bit-level SPI byte shifter between the SD controller and the SD card pins. It takes one byte per handshake from the controller, shifts it out MSB-first on the command line (SPI mode 0), and captures the byte returned on the data line. It also drives the card clock and chip-select. It replaces ad-hoc strobe-based bit timing with a self-contained divider, so the controller works purely at byte level.

## Interface
Parameters:
- HALF_SLOW, default 100: clk cycles per SPI half-period in identification mode. Must be ≥1.
- HALF_FAST, default 2: clk cycles per SPI half-period in data mode. Must be ≥1.

Ports (clock and reset first):
- clk  in  1  system clock; the single clock of the block.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request to transfer tx_data; accepted only when busy=0.
- tx_data  in  8  byte to send, sampled on the accepting edge.
- fast  in  1  selects HALF_FAST (1) or HALF_SLOW (0); sampled on the accepting edge.
- cs_assert  in  1  1 = select the card.
- crc_clear  in  1  clears the CRC7 accumulator.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse; rx_data is valid in this cycle.
- rx_data  out  8  last received byte; held until the next done.
- crc7  out  7  running CRC7 over transmitted bits.
- sd_clk  out  1  SPI clock to the card.
- sd_cmd  out  1  MOSI to the card.
- sd_cs_n  out  1  active-low chip-select.
- sd_miso  in  1  card data out (DAT0).

## Operation
- States: IDLE, LOW, HIGH, DONE.
- **IDLE**
  - sd_clk=0, sd_cmd=1.
  - sd_cs_n follows ~cs_assert, registered with one cycle of latency.
  - start=1 latches tx_data and the half-period H (from fast). It drives sd_cmd=tx_data[7], loads the divider with H-1 and bit_cnt=0, then goes to LOW.
- **LOW**
  - Divider counts down.
  - At 0: sd_clk←1, shift sd_miso into rx_shift LSB, reload H-1, go to HIGH.
- **HIGH**
  - At 0: sd_clk←0.
  - If bit_cnt=7, go to DONE.
  - Otherwise bit_cnt+1, sd_cmd←next bit (MSB-first), reload, go to LOW.
- **DONE**
  - done=1 and rx_data←rx_shift for one cycle.
  - sd_cmd←1, return to IDLE.
- busy=1 in LOW, HIGH and DONE.
- start while busy is ignored and not queued. start in the DONE cycle is also ignored.
- cs_assert changes during a transfer are held off. sd_cs_n updates only in IDLE, so CS never toggles mid-byte.
- fast changes mid-byte do not affect the current byte.
- Divider width is $clog2(max(HALF_SLOW,HALF_FAST)). Its reload value is H-1, so H=1 gives one-cycle half-periods.

## Timing
- Reset values:
  - state=IDLE, busy=0, done=0, rx_data=8'h00, crc7=7'h00.
  - sd_clk=0, sd_cmd=1, sd_cs_n=1.
- Reset mid-transfer aborts immediately (asynchronous). No done pulse is produced.
- Latency: done is high exactly 16·H+1 cycles after the edge that samples start. The next start may be accepted on the cycle after done.
- MOSI changes on the falling edge of sd_clk (bit 7 changes on the start edge). MISO is sampled on the rising edge. Setup is H cycles.
- Every output is registered. No combinational path exists from inputs to pins.

## Configuration
- SD_SPI_CRC7_EN defined:
  - crc7 updates on each rising sd_clk edge with the transmitted bit, polynomial x^7+x^3+1, init 0.
  - crc_clear zeroes it in any state. If crc_clear and the first bit of a byte coincide, the clear takes priority and that bit is still folded in on its rising edge.
- SD_SPI_CRC7_EN undefined:
  - The accumulator is absent, crc7 is tied to 7'h00 and crc_clear is ignored.

## Structure
- Package sd_spi_pkg holds:
  - state enum (IDLE/LOW/HIGH/DONE)
  - CRC7_POLY = 7'h09
  - SD_IDLE_BYTE = 8'hFF
- Sub-module sd_crc7: bit-serial CRC7 with inputs clk, reset, clear, en, bit_in and output crc. It is instantiated only under SD_SPI_CRC7_EN.

## Test plan
- Reset: assert reset mid-byte → sd_clk=0, sd_cmd=1, sd_cs_n=1, busy=0, no done; the next start works normally.
- Loopback: HALF_FAST=2, fast=1, sd_miso tied to sd_cmd, send 8'hA5 → rx_data=8'hA5; done 33 cycles after start; 8 sd_clk pulses, each 2 cycles high.
- Receive: send 8'hFF while the card model returns 8'h01 MSB-first on rising edges → rx_data=8'h01; sd_cmd is 1 throughout.
- Slow mode: fast=0, HALF_SLOW=100 → done 1601 cycles after start. A start pulsed at cycle 500 is ignored; only one done occurs.
- CS hold-off: drop cs_assert mid-byte → sd_cs_n stays 0 until IDLE, rises the cycle after returning to IDLE.
- CRC7 (with SD_SPI_CRC7_EN): crc_clear, then send 40 00 00 00 00 → crc7=7'h4A (CRC byte 8'h95); without the macro, crc7=0.

Source files
------------

// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD SPI byte engine.
package sd_spi_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLow,
        StHigh,
        StDone
    } sd_state_e;

    localparam logic [6:0] CRC7_POLY    = 7'h09;
    localparam logic [7:0] SD_IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/sd_crc7.sv
// Bit-serial CRC7 (x^7 + x^3 + 1, init 0); clear has priority over en.
module sd_crc7
    import sd_spi_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    input  logic       bit_in,
    output logic [6:0] crc
);

    logic [6:0] crc_q, crc_d;
    logic       feedback;

    always_comb begin
        crc_d    = crc_q;
        feedback = crc_q[6] ^ bit_in;
        if (clear) begin
            crc_d = '0;
        end else if (en) begin
            crc_d = {crc_q[5:0], 1'b0} ^ (feedback ? CRC7_POLY : 7'h00);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/sd_spi_byte_engine.sv
// SPI mode-0 byte shifter for the SD card pins with an internal half-period divider.
// Optional CRC7 accumulator over transmitted bits is enabled by defining SD_SPI_CRC7_EN.
module sd_spi_byte_engine
    import sd_spi_pkg::*;
#(
    parameter int unsigned HALF_SLOW = 100,
    parameter int unsigned HALF_FAST = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx_data,
    input  logic       fast,
    input  logic       cs_assert,
    input  logic       crc_clear,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_data,
    output logic [6:0] crc7,
    output logic       sd_clk,
    output logic       sd_cmd,
    output logic       sd_cs_n,
    input  logic       sd_miso
);

    localparam int unsigned HALF_MAX = (HALF_SLOW > HALF_FAST) ? HALF_SLOW : HALF_FAST;
    localparam int unsigned DIV_W    = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;

    typedef logic [DIV_W-1:0] div_t;

    localparam div_t RELOAD_SLOW = div_t'(HALF_SLOW - 1);
    localparam div_t RELOAD_FAST = div_t'(HALF_FAST - 1);
    localparam logic CMD_IDLE    = SD_IDLE_BYTE[7];

    sd_state_e  state_q, state_d;
    div_t       div_q, div_d;
    div_t       reload_q, reload_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       sd_clk_q, sd_clk_d;
    logic       sd_cmd_q, sd_cmd_d;
    logic       sd_cs_n_q, sd_cs_n_d;
    logic       crc_en;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        reload_d   = reload_q;
        bit_cnt_d  = bit_cnt_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        done_d     = 1'b0;
        sd_clk_d   = sd_clk_q;
        sd_cmd_d   = sd_cmd_q;
        sd_cs_n_d  = sd_cs_n_q;
        crc_en     = 1'b0;

        unique case (state_q)
            StIdle: begin
                sd_clk_d  = 1'b0;
                sd_cmd_d  = CMD_IDLE;
                // Chip-select only tracks the controller between bytes.
                sd_cs_n_d = ~cs_assert;
                if (start) begin
                    tx_shift_d = tx_data;
                    sd_cmd_d   = tx_data[7];
                    reload_d   = fast ? RELOAD_FAST : RELOAD_SLOW;
                    div_d      = reload_d;
                    bit_cnt_d  = 3'd0;
                    state_d    = StLow;
                end
            end
            StLow: begin
                if (div_q == '0) begin
                    sd_clk_d   = 1'b1;
                    rx_shift_d = {rx_shift_q[6:0], sd_miso};
                    crc_en     = 1'b1;
                    div_d      = reload_q;
                    state_d    = StHigh;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            StHigh: begin
                if (div_q == '0) begin
                    sd_clk_d = 1'b0;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StDone;
                    end else begin
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        sd_cmd_d   = tx_shift_q[6];
                        div_d      = reload_q;
                        state_d    = StLow;
                    end
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            StDone: begin
                done_d    = 1'b1;
                rx_data_d = rx_shift_q;
                sd_cmd_d  = CMD_IDLE;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            div_q      <= '0;
            reload_q   <= '0;
            bit_cnt_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sd_clk_q   <= 1'b0;
            sd_cmd_q   <= CMD_IDLE;
            sd_cs_n_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            reload_q   <= reload_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sd_clk_q   <= sd_clk_d;
            sd_cmd_q   <= sd_cmd_d;
            sd_cs_n_q  <= sd_cs_n_d;
        end
    end

`ifdef SD_SPI_CRC7_EN
    sd_crc7 u_crc7 (
        .clk    (clk),
        .reset  (reset),
        .clear  (crc_clear),
        .en     (crc_en),
        .bit_in (sd_cmd_q),
        .crc    (crc7)
    );
`else
    logic unused_crc;
    assign unused_crc = ^{crc_clear, crc_en};
    assign crc7       = 7'h00;
`endif

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign sd_clk  = sd_clk_q;
    assign sd_cmd  = sd_cmd_q;
    assign sd_cs_n = sd_cs_n_q;

endmodule

// File: tb/tb_sd_spi_byte_engine.sv
// Self-checking bench for sd_spi_byte_engine: scoreboard on rx_data plus per-scenario checks.
module tb_sd_spi_byte_engine;

    localparam int unsigned HS = 100;
    localparam int unsigned HF = 2;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       start     = 1'b0;
    logic [7:0] tx_data   = 8'h00;
    logic       fast      = 1'b0;
    logic       cs_assert = 1'b0;
    logic       crc_clear = 1'b0;
    logic       sd_miso;
    logic       busy, done, sd_clk, sd_cmd, sd_cs_n;
    logic [7:0] rx_data;
    logic [6:0] crc7;

    logic       loopback = 1'b1;
    logic [7:0] card_sr  = 8'hFF;

    int checks     = 0;
    int errors     = 0;
    int done_count = 0;
    logic [7:0] exp_q[$];

    sd_spi_byte_engine #(
        .HALF_SLOW (HS),
        .HALF_FAST (HF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .tx_data   (tx_data),
        .fast      (fast),
        .cs_assert (cs_assert),
        .crc_clear (crc_clear),
        .busy      (busy),
        .done      (done),
        .rx_data   (rx_data),
        .crc7      (crc7),
        .sd_clk    (sd_clk),
        .sd_cmd    (sd_cmd),
        .sd_cs_n   (sd_cs_n),
        .sd_miso   (sd_miso)
    );

    always #5 clk = ~clk;

    // Card model: presents its next bit after every falling sd_clk.
    assign sd_miso = loopback ? sd_cmd : card_sr[7];
    always @(negedge sd_clk) card_sr = {card_sr[6:0], 1'b1};

    always @(negedge clk) begin
        if (!reset && done === 1'b1) begin
            logic [7:0] exp;
            done_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_unexpected_done rx_data=%h required=no done", rx_data);
            end else begin
                exp = exp_q.pop_front();
                if (rx_data !== exp) begin
                    errors++;
                    $display("FAIL scoreboard_rx_data got=%h required=%h", rx_data, exp);
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic f, input logic push,
                        input logic [7:0] exp_rx);
        @(negedge clk);
        tx_data = d;
        fast    = f;
        start   = 1'b1;
        if (push) exp_q.push_back(exp_rx);
        @(negedge clk);
        start   = 1'b0;
        tx_data = 8'h00;
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        int n;
        int dc0;
        reset     = 1'b1;
        cs_assert = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, sd_clk, sd_cmd, sd_cs_n, rx_data, crc7} !==
            {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 7'h00}) begin
            errors++;
            $display("FAIL reset_values got=%b_%b_%b_%b_%b_%h_%h required=0_0_0_1_1_00_00",
                     busy, done, sd_clk, sd_cmd, sd_cs_n, rx_data, crc7);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (sd_cs_n !== 1'b0) begin
            errors++;
            $display("FAIL cs_follow got=%b required=0", sd_cs_n);
        end
        dc0 = done_count;
        send(8'h3C, 1'b1, 1'b0, 8'h00);
        repeat (9) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_mid_byte got=%b required=1", busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({sd_clk, sd_cmd, sd_cs_n, busy, done} !== 5'b01100) begin
            errors++;
            $display("FAIL reset_abort got=%b required=01100",
                     {sd_clk, sd_cmd, sd_cs_n, busy, done});
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        checks++;
        if (done_count != dc0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done got=%0d,%b required=%0d,0", done_count, busy, dc0);
        end
        send(8'h96, 1'b1, 1'b1, 8'h96);
        wait_done(100, n);
        checks++;
        if (n != 33) begin
            errors++;
            $display("FAIL post_reset_latency got=%0d required=33", n);
        end
        @(negedge clk);
    endtask

    task automatic test_loopback;
        int n, run, pulses, badw;
        loopback = 1'b1;
        send(8'hA5, 1'b1, 1'b1, 8'hA5);
        n = 0; run = 0; pulses = 0; badw = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
            if (sd_clk === 1'b1) begin
                run++;
            end else if (run != 0) begin
                pulses++;
                if (run != 2) badw++;
                run = 0;
            end
        end
        checks++;
        if (n != 33) begin
            errors++;
            $display("FAIL loopback_latency got=%0d required=33", n);
        end
        checks++;
        if (pulses != 8 || badw != 0) begin
            errors++;
            $display("FAIL loopback_clk_pulses got=%0d,%0d required=8,0", pulses, badw);
        end
        checks++;
        if (rx_data !== 8'hA5) begin
            errors++;
            $display("FAIL loopback_rx got=%h required=a5", rx_data);
        end
        @(negedge clk);
    endtask

    task automatic test_receive;
        int n, cmdbad;
        loopback = 1'b0;
        @(negedge clk);
        card_sr = 8'h01;
        send(8'hFF, 1'b1, 1'b1, 8'h01);
        n = 0; cmdbad = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
            if (sd_cmd !== 1'b1) cmdbad++;
        end
        checks++;
        if (cmdbad != 0 || n != 33) begin
            errors++;
            $display("FAIL receive_cmd_high got=%0d,%0d required=0,33", cmdbad, n);
        end
        checks++;
        if (rx_data !== 8'h01) begin
            errors++;
            $display("FAIL receive_rx got=%h required=01", rx_data);
        end
        loopback = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_slow;
        int n, dc0;
        dc0 = done_count;
        send(8'h5A, 1'b0, 1'b1, 8'h5A);
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
            if (n == 500) begin
                start   = 1'b1;
                tx_data = 8'h11;
            end else if (n == 501) begin
                start   = 1'b0;
                tx_data = 8'h00;
            end
        end
        checks++;
        if (n != 1601) begin
            errors++;
            $display("FAIL slow_latency got=%0d required=1601", n);
        end
        repeat (40) @(negedge clk);
        checks++;
        if (done_count - dc0 != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL slow_single_done got=%0d,%b required=1,0", done_count - dc0, busy);
        end
    endtask

    task automatic test_done_cycle_start;
        int n, dc0;
        dc0 = done_count;
        send(8'hC3, 1'b1, 1'b1, 8'hC3);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
            if (n == 32) begin
                start   = 1'b1;
                tx_data = 8'h77;
            end
        end
        start   = 1'b0;
        tx_data = 8'h00;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || n != 33) begin
            errors++;
            $display("FAIL done_cycle_start got=%b,%0d required=0,33", busy, n);
        end
        repeat (40) @(negedge clk);
        checks++;
        if (done_count - dc0 != 1) begin
            errors++;
            $display("FAIL done_cycle_single got=%0d required=1", done_count - dc0);
        end
    endtask

    task automatic test_cs_holdoff;
        int n, csbad;
        cs_assert = 1'b1;
        repeat (2) @(negedge clk);
        send(8'h81, 1'b1, 1'b1, 8'h81);
        n = 0; csbad = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
            if (n == 10) cs_assert = 1'b0;
            if (sd_cs_n !== 1'b0) csbad++;
        end
        checks++;
        if (csbad != 0) begin
            errors++;
            $display("FAIL cs_holdoff got=%0d required=0", csbad);
        end
        @(negedge clk);
        checks++;
        if (sd_cs_n !== 1'b1) begin
            errors++;
            $display("FAIL cs_release got=%b required=1", sd_cs_n);
        end
        cs_assert = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_crc;
        int n;
        logic [7:0] cmd0 [5];
        logic [6:0] exp_crc;
`ifdef SD_SPI_CRC7_EN
        exp_crc = 7'h4A;
`else
        exp_crc = 7'h00;
`endif
        cmd0 = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
        // Clear coincides with the first start; the first bit must still be folded in.
        @(negedge clk);
        tx_data   = cmd0[0];
        fast      = 1'b1;
        start     = 1'b1;
        crc_clear = 1'b1;
        exp_q.push_back(cmd0[0]);
        @(negedge clk);
        start     = 1'b0;
        crc_clear = 1'b0;
        wait_done(100, n);
        @(negedge clk);
        for (int i = 1; i < 5; i++) begin
            send(cmd0[i], 1'b1, 1'b1, cmd0[i]);
            wait_done(100, n);
            @(negedge clk);
        end
        checks++;
        if (crc7 !== exp_crc) begin
            errors++;
            $display("FAIL crc7_cmd0 got=%h required=%h", crc7, exp_crc);
        end
        crc_clear = 1'b1;
        @(negedge clk);
        crc_clear = 1'b0;
        checks++;
        if (crc7 !== 7'h00) begin
            errors++;
            $display("FAIL crc7_clear got=%h required=00", crc7);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_receive();
        test_slow();
        test_done_cycle_start();
        test_cs_holdoff();
        test_crc();
        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout got=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
